// File: rtl/pmodacl2_sequencer_pkg.sv
// Shared constants and state encoding for the ADXL362 (PmodACL2) sequencer.
package pmodacl2_sequencer_pkg;

  // ADXL362 command codes
  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  // ADXL362 register addresses
  localparam logic [7:0] REG_DEVID_AD   = 8'h00;
  localparam logic [7:0] REG_XDATA_L    = 8'h0E;
  localparam logic [7:0] REG_FILTER_CTL = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;

  // Expected DEVID_AD contents and the POWER_CTL value selecting measurement mode
  localparam logic [7:0] DEVID_AD_VAL  = 8'hAD;
  localparam logic [7:0] POWER_MEASURE = 8'h02;

  // Index of the final byte of a 3-byte register access and of the 8-byte XYZ burst
  localparam logic [2:0] LAST_CFG_IDX = 3'd2;
  localparam logic [2:0] LAST_XYZ_IDX = 3'd7;

  typedef enum logic [2:0] {
    ST_PWRUP    = 3'd0,
    ST_ID_RD    = 3'd1,
    ST_CFG_FILT = 3'd2,
    ST_CFG_PWR  = 3'd3,
    ST_WAIT     = 3'd4,
    ST_XYZ_RD   = 3'd5,
    ST_GAP      = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

  // Byte ROM: MOSI byte number idx of the transaction run in state s.
  function automatic logic [7:0] seq_byte(input state_t s, input logic [2:0] idx,
                                          input logic [7:0] filter_val);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      ST_ID_RD: begin
        if (idx == 3'd0) b = CMD_RD;
        else if (idx == 3'd1) b = REG_DEVID_AD;
      end
      ST_CFG_FILT: begin
        if (idx == 3'd0) b = CMD_WR;
        else if (idx == 3'd1) b = REG_FILTER_CTL;
        else b = filter_val;
      end
      ST_CFG_PWR: begin
        if (idx == 3'd0) b = CMD_WR;
        else if (idx == 3'd1) b = REG_POWER_CTL;
        else b = POWER_MEASURE;
      end
      ST_XYZ_RD: begin
        if (idx == 3'd0) b = CMD_RD;
        else if (idx == 3'd1) b = REG_XDATA_L;
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pmodacl2_sequencer.sv
// ADXL362 bring-up and periodic XYZ sampling sequencer driving an external
// byte-level SPI engine. Checks DEVID, programs FILTER_CTL and POWER_CTL,
// then reads the six XYZ data bytes every SAMPLE_PERIOD cycles.
//
// Byte handshake with the SPI engine: spi_start_o is a one-cycle request
// carrying spi_tx_o; exactly one byte may be outstanding, and it completes on
// the one-cycle spi_done_i pulse with spi_rx_i valid in that same cycle.
// spi_done_i arriving while no byte is outstanding is ignored. The next
// request is issued the cycle after a completion.
module pmodacl2_sequencer
  import pmodacl2_sequencer_pkg::*;
#(
  parameter int         PWRUP_CYCLES  = 500,
  parameter int         SAMPLE_PERIOD = 100000,
  parameter int         CS_GAP        = 8,
  parameter logic [7:0] FILTER_VAL    = 8'h13
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        spi_start_o,
  output logic [7:0]  spi_tx_o,
  input  logic        spi_done_i,
  input  logic [7:0]  spi_rx_i,
  output logic        ncs_o,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic [15:0] z_o,
  output logic        sample_valid_o,
  output logic        ready_o,
  output logic        id_error_o,
  output logic [2:0]  state_o
);

  localparam int PWR_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

  state_t            state_q, state_d;
  state_t            gap_next_q, gap_next_d;   // where GAP goes when it expires
  logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;     // cycles since the last XYZ launch
  logic [2:0]        byte_idx_q, byte_idx_d;   // byte number inside the transaction
  logic              busy_q, busy_d;           // a byte is outstanding at the engine
  logic              ncs_q, ncs_d;
  logic              spi_start_q, spi_start_d;
  logic [7:0]        spi_tx_q, spi_tx_d;
  logic [39:0]       stage_q, stage_d;         // XL, XH, YL, YH, ZL (ZH arrives last)
  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic [15:0]       z_q, z_d;
  logic              sample_valid_q, sample_valid_d;
  logic              ready_q, ready_d;
  logic              id_error_q, id_error_d;
  logic [2:0]        last_idx;

  // Next-state, byte sequencing, counters and output computation
  always_comb begin
    state_d        = state_q;
    gap_next_d     = gap_next_q;
    pwr_cnt_d      = pwr_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    per_cnt_d      = per_cnt_q;
    byte_idx_d     = byte_idx_q;
    busy_d         = busy_q;
    ncs_d          = ncs_q;
    spi_start_d    = 1'b0;
    spi_tx_d       = spi_tx_q;
    stage_d        = stage_q;
    x_d            = x_q;
    y_d            = y_q;
    z_d            = z_q;
    sample_valid_d = 1'b0;
    ready_d        = ready_q;
    id_error_d     = id_error_q;
    last_idx       = (state_q == ST_XYZ_RD) ? LAST_XYZ_IDX : LAST_CFG_IDX;

    // The sample period runs across XYZ_RD, GAP and WAIT once configured and
    // saturates so a slow engine delays the next launch instead of wrapping.
    if (ready_q && (per_cnt_q != PER_LAST)) begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    case (state_q)
      ST_PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
          pwr_cnt_d = '0;
          state_d   = ST_ID_RD;
          ncs_d     = 1'b0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end

      ST_ID_RD, ST_CFG_FILT, ST_CFG_PWR, ST_XYZ_RD: begin
        if (!busy_q) begin
          // First byte: chip select went low in the previous cycle.
          spi_start_d = 1'b1;
          spi_tx_d    = seq_byte(state_q, byte_idx_q, FILTER_VAL);
          busy_d      = 1'b1;
        end else if (spi_done_i) begin
          if (state_q == ST_XYZ_RD) begin
            case (byte_idx_q)
              3'd2:    stage_d[7:0]   = spi_rx_i;
              3'd3:    stage_d[15:8]  = spi_rx_i;
              3'd4:    stage_d[23:16] = spi_rx_i;
              3'd5:    stage_d[31:24] = spi_rx_i;
              3'd6:    stage_d[39:32] = spi_rx_i;
              default: ;
            endcase
          end
          if (byte_idx_q == last_idx) begin
            busy_d     = 1'b0;
            byte_idx_d = '0;
            ncs_d      = 1'b1;
            gap_cnt_d  = '0;
            case (state_q)
              ST_ID_RD: begin
                if (spi_rx_i != DEVID_AD_VAL) begin
                  id_error_d = 1'b1;
                  state_d    = ST_ERROR;
                end else begin
                  state_d    = ST_GAP;
                  gap_next_d = ST_CFG_FILT;
                end
              end
              ST_CFG_FILT: begin
                state_d    = ST_GAP;
                gap_next_d = ST_CFG_PWR;
              end
              ST_CFG_PWR: begin
                state_d    = ST_GAP;
                gap_next_d = ST_WAIT;
              end
              default: begin
                // All three axes publish together with ZH straight from the engine.
                x_d            = stage_q[15:0];
                y_d            = stage_q[31:16];
                z_d            = {spi_rx_i, stage_q[39:32]};
                sample_valid_d = 1'b1;
                state_d        = ST_GAP;
                gap_next_d     = ST_WAIT;
              end
            endcase
          end else begin
            byte_idx_d  = byte_idx_q + 3'd1;
            spi_start_d = 1'b1;
            spi_tx_d    = seq_byte(state_q, byte_idx_q + 3'd1, FILTER_VAL);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = gap_next_q;
          if (gap_next_q == ST_WAIT) begin
            ready_d = 1'b1;
          end else begin
            ncs_d = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        if (per_cnt_q == PER_LAST) begin
          per_cnt_d = '0;
          state_d   = ST_XYZ_RD;
          ncs_d     = 1'b0;
        end
      end

      ST_ERROR: begin
        ncs_d   = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: ;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_PWRUP;
      gap_next_q     <= ST_PWRUP;
      pwr_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      per_cnt_q      <= '0;
      byte_idx_q     <= '0;
      busy_q         <= 1'b0;
      ncs_q          <= 1'b1;
      spi_start_q    <= 1'b0;
      spi_tx_q       <= 8'h00;
      stage_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      z_q            <= '0;
      sample_valid_q <= 1'b0;
      ready_q        <= 1'b0;
      id_error_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_next_q     <= gap_next_d;
      pwr_cnt_q      <= pwr_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      per_cnt_q      <= per_cnt_d;
      byte_idx_q     <= byte_idx_d;
      busy_q         <= busy_d;
      ncs_q          <= ncs_d;
      spi_start_q    <= spi_start_d;
      spi_tx_q       <= spi_tx_d;
      stage_q        <= stage_d;
      x_q            <= x_d;
      y_q            <= y_d;
      z_q            <= z_d;
      sample_valid_q <= sample_valid_d;
      ready_q        <= ready_d;
      id_error_q     <= id_error_d;
    end
  end

  assign spi_start_o    = spi_start_q;
  assign spi_tx_o       = spi_tx_q;
  assign ncs_o          = ncs_q;
  assign x_o            = x_q;
  assign y_o            = y_q;
  assign z_o            = z_q;
  assign sample_valid_o = sample_valid_q;
  assign ready_o        = ready_q;
  assign id_error_o     = id_error_q;
  assign state_o        = state_q;

endmodule

// File: doc/pmodacl2_sequencer.md
PMODACL2_SEQUENCER -- requirements
Module: pmodacl2_sequencer

Interface
REQ-001 Parameter PWRUP_CYCLES, default 500: clk_i cycles waited after reset before the first SPI transaction.
REQ-002 Parameter SAMPLE_PERIOD, default 100000: cycles between launches of successive XYZ reads; must be >= 64.
REQ-003 Parameter CS_GAP, default 8: minimum cycles ncs_o is held high between transactions.
REQ-004 Parameter FILTER_VAL, default 8'h13: value written to ADXL362 FILTER_CTL.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk_i  input  1  system clock; all logic on its rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 spi_start_o  output  1  one-cycle pulse; the byte engine shifts spi_tx_o.
REQ-009 spi_tx_o  output  8  byte to transmit; valid while spi_start_o=1.
REQ-010 spi_done_i  input  1  one-cycle pulse; byte complete, spi_rx_i valid.
REQ-011 spi_rx_i  input  8  byte received during the completed transfer.
REQ-012 ncs_o  output  1  ADXL362 chip select, active low.
REQ-013 x_o, y_o, z_o  output  16 each  last sampled axis data.
REQ-014 sample_valid_o  output  1  one-cycle pulse when x_o/y_o/z_o update.
REQ-015 ready_o  output  1  high once configuration is complete.
REQ-016 id_error_o  output  1  sticky; DEVID_AD mismatch.

Function
REQ-017 States: PWRUP, ID_RD, CFG_FILT, CFG_PWR, WAIT, XYZ_RD, GAP, ERROR.
REQ-018 PWRUP counts PWRUP_CYCLES, then goes to ID_RD.
REQ-019 Each transaction: ncs_o falls one cycle before the first spi_start_o; each subsequent spi_start_o is issued the cycle after the previous spi_done_i; ncs_o rises the cycle after the final spi_done_i.
REQ-020 Only one byte may be outstanding; spi_done_i is ignored when no byte is outstanding.
REQ-021 ID_RD sends 0x0B, 0x00, 0x00; if the third rx byte != 0xAD, set id_error_o and go to ERROR, else go to GAP then CFG_FILT.
REQ-022 CFG_FILT sends 0x0A, 0x2C, FILTER_VAL; then GAP; then CFG_PWR sends 0x0A, 0x2D, 0x02; then GAP; then WAIT with ready_o=1.
REQ-023 GAP holds ncs_o high for exactly CS_GAP cycles, then proceeds to the next state.
REQ-024 WAIT: the period counter reaches SAMPLE_PERIOD-1, then enters XYZ_RD; the counter restarts at the cycle ncs_o falls for XYZ_RD, so launches are exactly SAMPLE_PERIOD cycles apart.
REQ-025 XYZ_RD sends 0x0B, 0x0E, then six 0x00 bytes; rx bytes 3..8 = XL, XH, YL, YH, ZL, ZH.
REQ-026 Axis bytes are staged internally; x_o={XH,XL}, y_o={YH,YL}, z_o={ZH,ZL} all update together in the cycle ncs_o rises, and sample_valid_o pulses that cycle; there are no partial updates.
REQ-027 After XYZ_RD: GAP, then WAIT.
REQ-028 ERROR: ncs_o=1, no spi_start_o, ready_o=0; exits only on rst_i.
REQ-029 Counters are sized by $clog2 of their parameter and do not wrap within a state.

Reset
REQ-030 On rst_i: state=PWRUP; ncs_o=1; spi_start_o=0; spi_tx_o=0; x_o=y_o=z_o=0; sample_valid_o=0; ready_o=0; id_error_o=0; all counters=0.
REQ-031 When rst_i is asserted mid-transaction, ncs_o is 1 at the next edge, and any later spi_done_i is ignored.

Structure
REQ-032 A shared package header holds: command codes (WR=0x0A, RD=0x0B), register addresses (DEVID_AD=0x00, XDATA_L=0x0E, FILTER_CTL=0x2C, POWER_CTL=0x2D), the DEVID value 0xAD, and state encodings.
REQ-033 The byte-level SPI engine is external; the sequencer has no sub-module. The byte ROM and the counters are inline.

Verification
REQ-034 Reset, then SPI model returns DEVID 0xAD -> MOSI bytes 0B 00 00 | 0A 2C 13 | 0A 2D 02; ready_o rises after the third transaction; ncs_o high >= CS_GAP between transactions.
REQ-035 Model returns 0x55 for DEVID -> id_error_o=1, ready_o stays 0, no further ncs_o falls for 10000 cycles.
REQ-036 Model data XL..ZH = 34 12 CD AB 01 80 -> x_o=16'h1234, y_o=16'hABCD, z_o=16'h8001, single sample_valid_o pulse coincident with ncs_o rising.
REQ-037 SAMPLE_PERIOD=200 -> successive XYZ ncs_o falling edges exactly 200 cycles apart over 5 samples.
REQ-038 rst_i asserted after the 4th byte of XYZ_RD -> ncs_o=1 next cycle, outputs zero, sequence restarts from PWRUP; the stray spi_done_i is ignored.
REQ-039 Variable engine latency (1..40 cycles per byte) -> spi_start_o never issued while a byte is outstanding; data stays correct.
